conv_encoder: RTL and testbench
===============================

// Module: conv_encoder
// PURPOSE
//  Rate-1/2 feed-forward convolutional encoder, the transmit-side counterpart of the Viterbi
//  decoder (BMC/ACS/traceback). Takes a framed serial bit stream and emits one 2-bit code
//  symbol per accepted bit. Appends K-1 zero tail bits per frame so every frame ends in state 0,
//  the state the decoder's traceback starts from. Valid/ready on both sides; registered output.
// PARAMETERS
//  K       3       constraint length (>=2); encoder state is K-1 bits
//  G0      3'b111  generator for out_sym[1], K bits, MSB taps the current input bit
//  G1      3'b101  generator for out_sym[0], K bits, MSB taps the current input bit
//  TAIL_EN 1       1: append K-1 zero tail symbols per frame; 0: no tail, state cleared after in_last
// PORTS
//  clk       in   1  clock, all logic on rising edge
//  rst_n     in   1  asynchronous active-low reset
//  in_valid  in   1  in_bit/in_last valid
//  in_bit    in   1  data bit to encode
//  in_last   in   1  bit is the last data bit of the frame
//  in_ready  out  1  encoder accepts the input this cycle
//  out_valid out  1  out_sym/out_last valid
//  out_sym   out  2  code symbol {c0,c1} = {G0 parity, G1 parity}
//  out_last  out  1  final symbol of the frame (last tail symbol, or in_last's symbol if TAIL_EN=0)
//  out_ready in   1  downstream accepts the symbol
//  busy      out  1  frame in progress or symbol pending (state!=IDLE || out_valid)
// BEHAVIOUR
//  Reset: async clear. out_valid=0, out_sym=0, out_last=0, sr=0, tail_cnt=0, state=IDLE, busy=0.
//   in_ready is forced to 0 while rst_n=0. Reset mid-frame discards all frame and pending data.
//  Shift reg sr[K-2:0], sr[K-2] = most recent bit. Tap vector v = {b, sr[K-2:0]}.
//   c0 = ^(v & G0), c1 = ^(v & G1). Update on load: sr <= {b, sr[K-2:1]}.
//  load = (!out_valid || out_ready): output slot is free or drains this cycle.
//  in_ready = load && state!=TAIL (combinational). Accept = in_valid && in_ready.
//  On accept: out_sym <= {c0,c1} with b=in_bit, out_valid <= 1, sr shifts; latency 1 cycle.
//  out_valid && !out_ready: out_sym, out_last held stable; no load; in_ready=0.
//  out_valid cleared only when out_ready=1 and nothing new loads that cycle.
//  FSM:
//   IDLE: sr==0. Accept -> DATA (or TAIL/IDLE if in_last, per below).
//   DATA: Accept with in_last=0 -> stay.
//    Accept with in_last=1: TAIL_EN=1 -> TAIL, tail_cnt<=K-1, out_last<=0;
//    TAIL_EN=0 -> IDLE, out_last<=1, sr<=0.
//   TAIL: each cycle with load=1 emits a symbol with b=0, tail_cnt decrements; when tail_cnt==1
//    that symbol carries out_last=1, sr<=0, -> IDLE. in_valid ignored during TAIL.
//  Throughput: 1 symbol/cycle with out_ready=1; K-1 input bubble cycles per frame when TAIL_EN=1.
//  Single-bit frame (first bit has in_last=1) is legal: 1 data + K-1 tail symbols.
//  No in-band start marker: first accept in IDLE starts a frame; frames separated only by in_last.
// TESTING (K=3, G0=111, G1=101, TAIL_EN=1 unless noted)
//  1 Reset: rst_n=0 -> out_valid=0, out_sym=00, busy=0, in_ready=0; release -> in_ready=1.
//  2 Frame 1,0,1,1(last), out_ready=1 -> out_sym 11,10,00,01,01,11; out_last only on 6th; busy=0 after.
//  3 Same frame, out_ready=0 for 3 cycles after 2nd symbol -> out_sym held at 10, in_ready=0,
//    identical 6-symbol sequence afterwards, nothing lost or duplicated.
//  4 Frame 1(last), in_valid=1 held during tail -> 11,10,11 with out_last on 3rd, in_ready=0
//    for 2 cycles; next frame 1(last) again yields 11,10,11 (state returned to 0).
//  5 Assert rst_n=0 during TAIL of frame 2 -> out_valid=0 immediately; after release,
//    frame 1(last) yields 11,10,11.
//  6 TAIL_EN=0, frame 1,1(last) -> 11,01 with out_last on 2nd; next frame 1(last) -> 11.

Source files
------------

// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder with optional zero-tail termination.
// Accepts one framed bit per handshake and emits one registered 2-bit code symbol.
module conv_encoder #(
    parameter int           K       = 3,
    parameter logic [K-1:0] G0      = 3'b111,
    parameter logic [K-1:0] G1      = 3'b101,
    parameter int           TAIL_EN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_valid,
    output logic [1:0] out_sym,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy
);

    localparam int SR_W  = K - 1;
    localparam int CNT_W = (K > 2) ? $clog2(K) : 1;
    localparam logic [CNT_W-1:0] TAIL_LEN = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SR_W-1:0]  sr;
    logic [CNT_W-1:0] tail_cnt;

    logic             vld_p1;
    logic [1:0]       sym_p1;
    logic             last_p1;

    logic             load;
    logic             accept;
    logic             tail_step;
    logic             tail_done;
    logic             frame_end;
    logic             shift;
    logic             b_p0;
    logic [K-1:0]     v_p0;
    logic [1:0]       sym_p0;
    logic [SR_W-1:0]  sr_nxt;

    function automatic logic parity(input logic [K-1:0] v, input logic [K-1:0] g);
        return ^(v & g);
    endfunction

    // Newest bit enters at the MSB; the oldest bit falls off the LSB.
    function automatic logic [SR_W-1:0] shift_in(input logic b, input logic [SR_W-1:0] s);
        logic [K-1:0] ext;
        ext = {b, s};
        return ext[K-1:1];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DATA: begin
                if (accept) begin
                    if (!in_last) begin
                        state_nxt = DATA;
                    end else if (TAIL_EN != 0) begin
                        state_nxt = TAIL;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            TAIL: begin
                if (tail_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load      = !vld_p1 || out_ready;
        in_ready  = rst_n && load && (state != TAIL);
        accept    = in_valid && in_ready;
        tail_step = load && (state == TAIL);
        tail_done = tail_step && (tail_cnt == CNT_ONE);
        frame_end = tail_done || (accept && in_last && (TAIL_EN == 0));
        shift     = accept || tail_step;
        busy      = (state != IDLE) || vld_p1;
    end

    // Stage p0: tap vector and parity of the bit being loaded (zero during tail).
    always_comb begin
        b_p0   = accept ? in_bit : 1'b0;
        v_p0   = {b_p0, sr};
        sym_p0 = {parity(v_p0, G0), parity(v_p0, G1)};
        sr_nxt = shift_in(b_p0, sr);
    end

    // Stage p1: output register; holds while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            sym_p1   <= 2'b00;
            last_p1  <= 1'b0;
            sr       <= '0;
            tail_cnt <= '0;
        end else begin
            if (shift) begin
                vld_p1  <= 1'b1;
                sym_p1  <= sym_p0;
                last_p1 <= frame_end;
                sr      <= frame_end ? '0 : sr_nxt;
            end else if (out_ready) begin
                vld_p1  <= 1'b0;
                last_p1 <= 1'b0;
            end

            if (accept && in_last && (TAIL_EN != 0)) begin
                tail_cnt <= TAIL_LEN;
            end else if (tail_step) begin
                tail_cnt <= tail_cnt - CNT_ONE;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_sym   = sym_p1;
    assign out_last  = last_p1;

endmodule

// File: tb/tb_conv_encoder.sv
// Directed scoreboard bench for conv_encoder: a tail-terminated instance and a no-tail instance.
module tb_conv_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       out_ready;

    logic       in_valid, in_bit, in_last, in_ready;
    logic       out_valid, out_last, busy;
    logic [1:0] out_sym;

    logic       in_valid0, in_bit0, in_last0, in_ready0;
    logic       out_valid0, out_last0, busy0;
    logic [1:0] out_sym0;

    int total = 0;
    int bad   = 0;

    logic [2:0] q  [$];
    logic [2:0] q0 [$];

    always #5 clk = ~clk;

    conv_encoder #(.K(3), .G0(3'b111), .G1(3'b101), .TAIL_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_bit(in_bit), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_sym(out_sym), .out_last(out_last),
        .out_ready(out_ready), .busy(busy)
    );

    conv_encoder #(.K(3), .G0(3'b111), .G1(3'b101), .TAIL_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid0), .in_bit(in_bit0), .in_last(in_last0), .in_ready(in_ready0),
        .out_valid(out_valid0), .out_sym(out_sym0), .out_last(out_last0),
        .out_ready(out_ready), .busy(busy0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every symbol that leaves on a handshake is popped and compared.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_ready) begin
            if (out_valid) begin
                if (q.size() == 0) check("unexpected_sym", 32'(q.size()), 32'd1);
                else check("sym_last", {29'd0, out_sym, out_last}, {29'd0, q.pop_front()});
            end
            if (out_valid0) begin
                if (q0.size() == 0) check("unexpected_sym0", 32'(q0.size()), 32'd1);
                else check("sym_last0", {29'd0, out_sym0, out_last0}, {29'd0, q0.pop_front()});
            end
        end
    end

    task automatic send_bit(input bit sel, input logic b, input logic l);
        int n;
        n = 0;
        if (sel) begin in_valid0 = 1'b1; in_bit0 = b; in_last0 = l; end
        else     begin in_valid  = 1'b1; in_bit  = b; in_last  = l; end
        @(negedge clk);
        while (!(sel ? in_ready0 : in_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!(sel ? in_ready0 : in_ready)) check("send_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        if (sel) begin in_valid0 = 1'b0; in_last0 = 1'b0; end
        else     begin in_valid  = 1'b0; in_last  = 1'b0; end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || busy0 || q.size() != 0 || q0.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_busy"}, {30'd0, busy, busy0}, 32'd0);
        check({tag, "_pending"}, 32'(q.size() + q0.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b1;
        in_valid = 0; in_bit = 0; in_last = 0;
        in_valid0 = 0; in_bit0 = 0; in_last0 = 0;

        // Reset state
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sym", {30'd0, out_sym}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {30'd0, in_ready, in_ready0}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("rel_in_ready", {30'd0, in_ready, in_ready0}, 32'd3);

        // Frame 1,0,1,1 with free-running sink
        q.push_back(3'b110); q.push_back(3'b100); q.push_back(3'b000);
        q.push_back(3'b010); q.push_back(3'b010); q.push_back(3'b111);
        send_bit(0, 1, 0); send_bit(0, 0, 0); send_bit(0, 1, 0); send_bit(0, 1, 1);
        wait_idle("t2");

        // Same frame, sink stalls three cycles after second symbol
        q.push_back(3'b110); q.push_back(3'b100); q.push_back(3'b000);
        q.push_back(3'b010); q.push_back(3'b010); q.push_back(3'b111);
        send_bit(0, 1, 0); send_bit(0, 0, 0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_sym", {29'd0, out_valid, out_sym}, 32'b110);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_bit(0, 1, 0); send_bit(0, 1, 1);
        wait_idle("t3");

        // Single-bit frame with in_valid held through the tail
        q.push_back(3'b110); q.push_back(3'b100); q.push_back(3'b111);
        send_bit(0, 1, 1);
        in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1;
        @(negedge clk);
        check("tail_in_ready_1", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("tail_in_ready_2", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        wait_idle("t4a");
        q.push_back(3'b110); q.push_back(3'b100); q.push_back(3'b111);
        send_bit(0, 1, 1);
        wait_idle("t4b");

        // Reset asserted during the tail of a frame
        q.push_back(3'b110); q.push_back(3'b100); q.push_back(3'b000); q.push_back(3'b010);
        send_bit(0, 1, 0); send_bit(0, 0, 0); send_bit(0, 1, 0); send_bit(0, 1, 1);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_pending", 32'(q.size()), 32'd0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 check("postrst_in_ready", {31'd0, in_ready}, 32'd1);
        q.push_back(3'b110); q.push_back(3'b100); q.push_back(3'b111);
        send_bit(0, 1, 1);
        wait_idle("t5");

        // No-tail instance: frame 1,1 then single-bit frame
        q0.push_back(3'b110); q0.push_back(3'b011);
        send_bit(1, 1, 0); send_bit(1, 1, 1);
        wait_idle("t6a");
        q0.push_back(3'b111);
        send_bit(1, 1, 1);
        wait_idle("t6b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
